mbm_pipe_mult: RTL and testbench

- Pipelined 8x8 unsigned Mitchell log-domain approximate multiplier. It is the stage directly downstream of the leading-one detector LOD and consumes its 3-bit k outputs.
- Flow: operands enter via a valid/ready handshake; two LOD instances find k1 and k2; the block forms log-domain mantissas, adds them, then antilogs to a 16-bit product.
- Sits between the operand source and the accumulator/output logic of the MBM datapath.

---
 rtl/mbm_pipe_mult_pkg.sv | 34 +++
 rtl/mbm_pipe_mult_lod.sv | 16 +
 rtl/mbm_pipe_mult.sv | 74 +++++++
 tb/tb_mbm_pipe_mult.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbm_pipe_mult_pkg.sv
// mbm_pipe_mult_pkg: widths, stage register layouts and the Mitchell antilog helper
package mbm_pipe_mult_pkg;

    localparam int N = 8;
    localparam int L = 3;
    localparam int F = 7;
    localparam int P = 16;
    localparam int W = 23;
    localparam logic [N-1:0] ANTILOG_THRESH = 8'd128;

    typedef struct packed {
        logic [L-1:0] k1;
        logic [L-1:0] k2;
        logic [F-1:0] x1;
        logic [F-1:0] x2;
        logic         zero;
    } s1_t;

    typedef struct packed {
        logic [L:0]   ks;
        logic [N-1:0] fs;
        logic         zero;
    } s2_t;

    // Antilog: a carry out of the mantissa sum (fs >= 128) doubles the mantissa instead of bumping the exponent
    function automatic logic [P-1:0] antilog(input logic [L:0] ks, input logic [N-1:0] fs);
        logic [N:0]   m;
        logic [W-1:0] w;
        m = (fs < ANTILOG_THRESH) ? ({1'b0, fs} + 9'd128) : {fs, 1'b0};
        w = {{(W-N-1){1'b0}}, m} << ks;
        return w[F+P-1:F];
    endfunction

endpackage

// File: rtl/mbm_pipe_mult_lod.sv
// mbm_pipe_mult_lod: leading-one detector, returns the index of the highest set bit (0 for zero input)
module mbm_pipe_mult_lod
    import mbm_pipe_mult_pkg::*;
(
    input  logic [N-1:0] v,
    output logic [L-1:0] k
);

    // Scan upward so the highest set bit wins
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) k = L'(i);
    end

endmodule

// File: rtl/mbm_pipe_mult.sv
// mbm_pipe_mult: 3-stage pipelined 8x8 Mitchell approximate multiplier with valid/ready flow control
module mbm_pipe_mult
    import mbm_pipe_mult_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] prod
);

    logic         v1, v2, v3;
    logic         rdy1, rdy2, rdy3;
    logic [L-1:0] k1, k2;
    logic [N-1:0] n1, n2;
    s1_t          s1;
    s2_t          s2;

    assign rdy3      = ~v3 | out_ready;
    assign rdy2      = ~v2 | rdy3;
    assign rdy1      = ~v1 | rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;

    mbm_pipe_mult_lod u_lod_a (.v(a), .k(k1));
    mbm_pipe_mult_lod u_lod_b (.v(b), .k(k2));

    assign n1 = a << (L'(F) - k1);
    assign n2 = b << (L'(F) - k2);

    // Stage 1: exponents and normalised fractions of both operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (rdy1) begin
            v1      <= in_valid;
            s1.k1   <= k1;
            s1.k2   <= k2;
            s1.x1   <= n1[F-1:0];
            s1.x2   <= n2[F-1:0];
            s1.zero <= (a == '0) | (b == '0);
        end
    end

    // Stage 2: log-domain addition of exponents and fractions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (rdy2) begin
            v2      <= v1;
            s2.ks   <= {1'b0, s1.k1} + {1'b0, s1.k2};
            s2.fs   <= {1'b0, s1.x1} + {1'b0, s1.x2};
            s2.zero <= s1.zero;
        end
    end

    // Stage 3: antilog back to a linear product, forced to zero for a zero operand
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3   <= 1'b0;
            prod <= '0;
        end else if (rdy3) begin
            v3   <= v2;
            prod <= s2.zero ? '0 : antilog(s2.ks, s2.fs);
        end
    end

endmodule

// File: tb/tb_mbm_pipe_mult.sv
// tb_mbm_pipe_mult: vector table, corner sequences and scoreboard-checked streams for mbm_pipe_mult
module tb_mbm_pipe_mult;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        int a;
        int b;
        int p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;

    logic        or_main = 1'b1;
    logic        or_rnd = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        use_tbl = 1'b0;
    logic [15:0] cur_exp = '0;
    int          errors = 0;
    int          checks = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    exp_t        sb[$];
    vec_t        tbl[10];

    assign out_ready = rnd_mode ? or_rnd : or_main;

    mbm_pipe_mult dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int msb(input int v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic int model(input int x, input int y);
        int k1, k2, fs, ks;
        if (x == 0 || y == 0) return 0;
        k1 = msb(x);
        k2 = msb(y);
        fs = ((x - (1 << k1)) << (7 - k1)) + ((y - (1 << k2)) << (7 - k2));
        ks = k1 + k2;
        if (fs < 128) return ((128 + fs) * (1 << ks)) / 128;
        return (2 * fs * (1 << ks)) / 128;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Scoreboard: record accepted operands, compare every delivered product in order
    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", {16'd0, prod}, 32'hffff_ffff);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("prod", {16'd0, prod}, e.p);
                    chk("prod_le_ab", (int'(prod) <= e.a * e.b) ? 1 : 0, 1);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{int'(a), int'(b), use_tbl ? int'(cur_exp) : model(int'(a), int'(b))});
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        int n;
        logic ok;
        n = 0;
        a = x;
        b = y;
        cur_exp = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 2000);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            idle(1);
            n++;
        end
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        int n, acc0, t0;
        logic [15:0] hold;
        tbl[0] = '{8'd8,   8'd4,   16'd32};
        tbl[1] = '{8'd3,   8'd3,   16'd8};
        tbl[2] = '{8'd5,   8'd6,   16'd28};
        tbl[3] = '{8'd255, 8'd255, 16'd65024};
        tbl[4] = '{8'd0,   8'd200, 16'd0};
        tbl[5] = '{8'd1,   8'd1,   16'd1};
        tbl[6] = '{8'd200, 8'd0,   16'd0};
        tbl[7] = '{8'd1,   8'd255, 16'd255};
        tbl[8] = '{8'd128, 8'd2,   16'd256};
        tbl[9] = '{8'd16,  8'd16,  16'd256};

        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_prod", {16'd0, prod}, 0);
        idle(2);
        rst = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 1);

        send(8'd8, 8'd4, 16'd32);
        n = 0;
        while (!out_valid && n < 20) begin
            idle(1);
            n++;
        end
        chk("latency", n + 1, 3);
        chk("latency_prod", {16'd0, prod}, 32);
        drain();

        use_tbl = 1'b1;
        for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].p);
        use_tbl = 1'b0;
        drain();

        or_main = 1'b0;
        acc0 = acc_cnt;
        fork
            begin
                send(8'd10, 8'd20, 16'd0);
                send(8'd77, 8'd99, 16'd0);
                send(8'd255, 8'd3, 16'd0);
                send(8'd64, 8'd64, 16'd0);
                send(8'd13, 8'd200, 16'd0);
            end
        join_none
        idle(8);
        chk("bp_accepts", acc_cnt - acc0, 3);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        chk("bp_head", {16'd0, prod}, model(10, 20));
        hold = prod;
        idle(4);
        chk("bp_hold_prod", {16'd0, prod}, {16'd0, hold});
        chk("bp_hold_valid", {31'd0, out_valid}, 1);
        or_main = 1'b1;
        wait fork;
        drain();

        or_main = 1'b0;
        send(8'd50, 8'd60, 16'd0);
        send(8'd51, 8'd61, 16'd0);
        send(8'd52, 8'd62, 16'd0);
        idle(2);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 0);
        chk("async_rst_prod", {16'd0, prod}, 0);
        idle(2);
        rst = 1'b0;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 0);
        or_main = 1'b1;
        idle(3);
        chk("post_rst_no_stale", {31'd0, out_valid}, 0);
        send(8'd7, 8'd9, 16'd0);
        drain();

        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            idle($urandom_range(0, 1));
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'd0);
        end
        drain();
        rnd_mode = 1'b0;

        t0 = cyc;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 256; j++)
                send(8'(i), 8'(j), 16'd0);
        chk("throughput_cycles", cyc - t0, 65536);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Random consumer stall pattern used during the throttled stream
    initial forever begin
        @(posedge clk);
        #1;
        or_rnd = 1'($urandom_range(0, 1));
    end

endmodule
